// File: rtl/circuito_exp5_pkg.sv
// Shared definitions for the sequence-memory game: state codes and the fixed play sequence.
package circuito_exp5_pkg;

    localparam logic [3:0] COD_INICIAL    = 4'h0;
    localparam logic [3:0] COD_PREPARACAO = 4'h1;
    localparam logic [3:0] COD_ESPERA     = 4'h2;
    localparam logic [3:0] COD_REGISTRA   = 4'h4;
    localparam logic [3:0] COD_COMPARACAO = 4'h5;
    localparam logic [3:0] COD_PROXIMO    = 4'h6;
    localparam logic [3:0] COD_FIM_ACERTO = 4'hA;
    localparam logic [3:0] COD_FIM_ERRO   = 4'hE;

    typedef enum logic [3:0] {
        ST_INICIAL    = COD_INICIAL,
        ST_PREPARACAO = COD_PREPARACAO,
        ST_ESPERA     = COD_ESPERA,
        ST_REGISTRA   = COD_REGISTRA,
        ST_COMPARACAO = COD_COMPARACAO,
        ST_PROXIMO    = COD_PROXIMO,
        ST_FIM_ACERTO = COD_FIM_ACERTO,
        ST_FIM_ERRO   = COD_FIM_ERRO
    } estado_t;

    localparam logic [3:0] ULTIMO_PASSO = 4'hF;

    // Sequence the player must reproduce, one one-hot switch per step.
    function automatic logic [3:0] rom_sequencia(input logic [3:0] endereco);
        logic [3:0] dado;
        dado = 4'h0;
        case (endereco)
            4'h0: dado = 4'h1;
            4'h1: dado = 4'h2;
            4'h2: dado = 4'h4;
            4'h3: dado = 4'h8;
            4'h4: dado = 4'h4;
            4'h5: dado = 4'h2;
            4'h6: dado = 4'h1;
            4'h7: dado = 4'h1;
            4'h8: dado = 4'h2;
            4'h9: dado = 4'h2;
            4'hA: dado = 4'h4;
            4'hB: dado = 4'h4;
            4'hC: dado = 4'h8;
            4'hD: dado = 4'h8;
            4'hE: dado = 4'h1;
            4'hF: dado = 4'h4;
            default: dado = 4'h0;
        endcase
        return dado;
    endfunction

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// Hex digit to 7-segment decoder, segments active-low in gfedcba order.
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    always_comb begin
        display = 7'h7F;
        case (hexa)
            4'h0: display = 7'h40;
            4'h1: display = 7'h79;
            4'h2: display = 7'h24;
            4'h3: display = 7'h30;
            4'h4: display = 7'h19;
            4'h5: display = 7'h12;
            4'h6: display = 7'h02;
            4'h7: display = 7'h78;
            4'h8: display = 7'h00;
            4'h9: display = 7'h10;
            4'hA: display = 7'h08;
            4'hB: display = 7'h03;
            4'hC: display = 7'h46;
            4'hD: display = 7'h21;
            4'hE: display = 7'h06;
            4'hF: display = 7'h0E;
            default: display = 7'h7F;
        endcase
    end

endmodule

// File: rtl/circuito_exp5.sv
// Sequence-memory game core: control FSM, datapath (counter, ROM, play register,
// comparator, play-edge detector) and the 7-segment debug displays.
//
//   state      | meaning
//   inicial    | idle after reset, waits for iniciar
//   preparacao | clears counter and play register
//   espera     | waits for a new switch play
//   registra   | latches the switches into the play register
//   comparacao | compares the play with ROM[contagem]
//   proximo    | advances to the next step
//   fim_acerto | whole sequence matched, waits for iniciar
//   fim_erro   | a play missed, waits for iniciar
module circuito_exp5
    import circuito_exp5_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    estado_t    estado;
    estado_t    estado_prox;
    logic [3:0] contagem;
    logic [3:0] jogada_reg;
    logic [3:0] memoria;
    logic       tem_jogada;
    logic       tem_jogada_q;
    logic       jogada;
    logic       igual;
    logic       fim;

    // Datapath
    assign memoria    = rom_sequencia(contagem);
    assign igual      = (jogada_reg == memoria);
    assign fim        = (contagem == ULTIMO_PASSO);
    assign tem_jogada = |chaves;
    // A held switch counts once: only the 0 -> nonzero transition is a play.
    assign jogada     = tem_jogada & ~tem_jogada_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tem_jogada_q <= 1'b0;
        end else begin
            tem_jogada_q <= tem_jogada;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= 4'h0;
        end else if (estado == ST_PREPARACAO) begin
            contagem <= 4'h0;
        end else if (estado == ST_PROXIMO) begin
            contagem <= contagem + 4'h1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada_reg <= 4'h0;
        end else if (estado == ST_PREPARACAO) begin
            jogada_reg <= 4'h0;
        end else if (estado == ST_REGISTRA) begin
            jogada_reg <= chaves;
        end
    end

    // Control unit: next-state logic
    always_comb begin
        estado_prox = estado;
        case (estado)
            ST_INICIAL:    if (iniciar) estado_prox = ST_PREPARACAO;
            ST_PREPARACAO: estado_prox = ST_ESPERA;
            ST_ESPERA:     if (jogada) estado_prox = ST_REGISTRA;
            ST_REGISTRA:   estado_prox = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!igual)
                    estado_prox = ST_FIM_ERRO;
                else if (fim)
                    estado_prox = ST_FIM_ACERTO;
                else
                    estado_prox = ST_PROXIMO;
            end
            ST_PROXIMO:    estado_prox = ST_ESPERA;
            ST_FIM_ACERTO: if (iniciar) estado_prox = ST_PREPARACAO;
            ST_FIM_ERRO:   if (iniciar) estado_prox = ST_PREPARACAO;
            default:       estado_prox = ST_INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= ST_INICIAL;
            acertou <= 1'b0;
            errou   <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            estado  <= estado_prox;
            acertou <= (estado_prox == ST_FIM_ACERTO);
            errou   <= (estado_prox == ST_FIM_ERRO);
            pronto  <= (estado_prox == ST_FIM_ACERTO) || (estado_prox == ST_FIM_ERRO);
        end
    end

    assign leds          = jogada_reg;
    assign db_igual      = igual;
    assign db_clock      = clock;
    assign db_iniciar    = iniciar;
    assign db_tem_jogada = tem_jogada;

    hexa7seg u_hex_contagem (
        .hexa    (contagem),
        .display (db_contagem)
    );

    hexa7seg u_hex_memoria (
        .hexa    (memoria),
        .display (db_memoria)
    );

    hexa7seg u_hex_estado (
        .hexa    (estado),
        .display (db_estado)
    );

    hexa7seg u_hex_jogada (
        .hexa    (jogada_reg),
        .display (db_jogadafeita)
    );

endmodule

// File: tb/tb_circuito_exp5.sv
// Scoreboard bench for circuito_exp5: stimulus queues expected snapshots and plays,
// a negedge monitor pops and compares them.
module tb_circuito_exp5;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves  = 4'h0;

    logic       acertou, errou, pronto, db_igual, db_clock, db_iniciar, db_tem_jogada;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] estado;
        logic [3:0] contagem;
        logic [3:0] memoria;
        logic       acertou;
        logic       errou;
        logic       pronto;
        logic [3:0] leds;
        logic       igual;
    } snap_t;

    typedef struct {
        logic [3:0] leds;
        logic       igual;
    } play_t;

    snap_t snap_q[$];
    play_t play_q[$];

    logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                             4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    circuito_exp5 dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .chaves         (chaves),
        .acertou        (acertou),
        .errou          (errou),
        .pronto         (pronto),
        .leds           (leds),
        .db_igual       (db_igual),
        .db_contagem    (db_contagem),
        .db_memoria     (db_memoria),
        .db_estado      (db_estado),
        .db_jogadafeita (db_jogadafeita),
        .db_clock       (db_clock),
        .db_iniciar     (db_iniciar),
        .db_tem_jogada  (db_tem_jogada)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: snapshots on request, play verdicts whenever the DUT shows comparacao.
    always @(negedge clock) begin
        snap_t s;
        play_t p;
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            chk({s.name, ".estado"},   {25'd0, db_estado},      {25'd0, seg(s.estado)});
            chk({s.name, ".contagem"}, {25'd0, db_contagem},    {25'd0, seg(s.contagem)});
            chk({s.name, ".memoria"},  {25'd0, db_memoria},     {25'd0, seg(s.memoria)});
            chk({s.name, ".jogada7"},  {25'd0, db_jogadafeita}, {25'd0, seg(s.leds)});
            chk({s.name, ".acertou"},  {31'd0, acertou},        {31'd0, s.acertou});
            chk({s.name, ".errou"},    {31'd0, errou},          {31'd0, s.errou});
            chk({s.name, ".pronto"},   {31'd0, pronto},         {31'd0, s.pronto});
            chk({s.name, ".leds"},     {28'd0, leds},           {28'd0, s.leds});
            chk({s.name, ".igual"},    {31'd0, db_igual},       {31'd0, s.igual});
            chk({s.name, ".iniciar"},  {31'd0, db_iniciar},     {31'd0, iniciar});
            chk({s.name, ".tem"},      {31'd0, db_tem_jogada},  {31'd0, |chaves});
        end
        if (reset && db_estado == seg(4'h5)) begin
            if (play_q.size() == 0) begin
                chk("unexpected_comparacao", 32'd1, 32'd0);
            end else begin
                p = play_q.pop_front();
                chk("play.leds",  {28'd0, leds},     {28'd0, p.leds});
                chk("play.igual", {31'd0, db_igual}, {31'd0, p.igual});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic snap(input string name, input logic [3:0] estado, input logic [3:0] contagem,
                        input logic [3:0] memoria, input logic acer, input logic err,
                        input logic pron, input logic [3:0] l, input logic ig);
        snap_t s;
        s.name = name; s.estado = estado; s.contagem = contagem; s.memoria = memoria;
        s.acertou = acer; s.errou = err; s.pronto = pron; s.leds = l; s.igual = ig;
        snap_q.push_back(s);
        for (int i = 0; i < 4 && snap_q.size() > 0; i++) @(negedge clock);
        if (snap_q.size() > 0) begin
            chk({name, ".timeout"}, 32'd1, 32'd0);
            snap_q.delete();
        end
        tick(1);
    endtask

    task automatic play(input logic [3:0] v, input logic ig);
        play_t p;
        p.leds = v; p.igual = ig;
        play_q.push_back(p);
        chaves = v;
        tick(10);
        chaves = 4'h0;
        tick(10);
    endtask

    task automatic start();
        iniciar = 1'b1;
        tick(5);
        iniciar = 1'b0;
        tick(2);
    endtask

    initial begin
        #2 reset = 1'b0;
        tick(1);
        snap("reset", 4'h0, 4'h0, 4'h1, 0, 0, 0, 4'h0, 0);
        reset = 1'b1;
        tick(2);

        iniciar = 1'b1;
        tick(5);
        iniciar = 1'b0;
        tick(10);
        snap("idle_espera", 4'h2, 4'h0, 4'h1, 0, 0, 0, 4'h0, 0);

        play(4'h1, 1);
        play(4'h2, 1);
        play(4'h4, 1);
        play(4'h8, 1);
        play(4'h1, 0);
        snap("fim_erro", 4'hE, 4'h4, 4'h4, 0, 1, 1, 4'h1, 0);
        tick(10);
        snap("fim_erro_hold", 4'hE, 4'h4, 4'h4, 0, 1, 1, 4'h1, 0);

        start();
        snap("restart", 4'h2, 4'h0, 4'h1, 0, 0, 0, 4'h0, 0);

        for (int i = 0; i < 16; i++) play(seq[i], 1);
        snap("fim_acerto", 4'hA, 4'hF, 4'h4, 1, 0, 1, 4'h4, 1);
        chaves = 4'h8;
        tick(20);
        chaves = 4'h0;
        tick(2);
        snap("fim_acerto_hold", 4'hA, 4'hF, 4'h4, 1, 0, 1, 4'h4, 1);

        start();
        for (int i = 0; i < 6; i++) play(seq[i], 1);
        snap("pre_reset", 4'h2, 4'h6, 4'h1, 0, 0, 0, 4'h2, 0);
        reset = 1'b0;
        snap("async_reset", 4'h0, 4'h0, 4'h1, 0, 0, 0, 4'h0, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        snap("after_reset_idle", 4'h0, 4'h0, 4'h1, 0, 0, 0, 4'h0, 0);

        start();
        play(4'h1, 1);
        snap("after_restart", 4'h2, 4'h1, 4'h2, 0, 0, 0, 4'h1, 0);

        chk("play_q_drained", play_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
